// File: rtl/counter_avg_pkg.sv
// Shared widths and defaults for the trigger-counter period averager.
package counter_avg_pkg;

    localparam int unsigned COUNTER_WIDTH_DEFAULT = 32;
    localparam int unsigned REJECT_COUNT_WIDTH    = 16;

    function automatic int unsigned sum_width(input int unsigned counter_width,
                                              input int unsigned avg_log2);
        return counter_width + avg_log2;
    endfunction

endpackage

// File: rtl/period_ring_buffer.sv
// Window storage: synchronous write at wr_ptr, combinational read of the same slot.
module period_ring_buffer
    import counter_avg_pkg::*;
#(
    parameter int unsigned WIDTH = COUNTER_WIDTH_DEFAULT,
    parameter int unsigned PTR_W = 3
) (
    input  logic             clk,
    input  logic             wr_en,
    input  logic [PTR_W-1:0] wr_ptr,
    input  logic [WIDTH-1:0] wr_data,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] mem [2**PTR_W];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_comb begin
        rd_data = mem[wr_ptr];
    end

endmodule

// File: rtl/counter_period_averager.sv
// Sliding-window average of completed trigger periods, feeding the trigger reference input.
// Optional outlier rejection (tolerance / rejected_count) is built with COUNTER_OUTLIER_REJECT_EN.
module counter_period_averager
    import counter_avg_pkg::*;
#(
    parameter int unsigned COUNTER_WIDTH = COUNTER_WIDTH_DEFAULT,
    parameter int unsigned AVG_LOG2      = 3
) (
    input  logic                     clk,
    input  logic                     aresetn,
    input  logic                     enable,
    input  logic                     freeze,
    input  logic                     period_strobe,
    input  logic [COUNTER_WIDTH-1:0] last_counter,
    input  logic [COUNTER_WIDTH-1:0] min_period,
    output logic [COUNTER_WIDTH-1:0] reference_counter,
    output logic                     reference_valid,
    output logic [AVG_LOG2:0]        fill_level,
    output logic                     sample_strobe
`ifdef COUNTER_OUTLIER_REJECT_EN
   ,input  logic [COUNTER_WIDTH-1:0]      tolerance,
    output logic [REJECT_COUNT_WIDTH-1:0] rejected_count
`endif
);

    localparam int unsigned N      = 1 << AVG_LOG2;
    localparam int unsigned PTR_W  = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
    localparam int unsigned SUM_W  = sum_width(COUNTER_WIDTH, AVG_LOG2);
    localparam int unsigned FILL_W = AVG_LOG2 + 1;
    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(N);
    localparam logic [PTR_W-1:0]  PTR_LAST  = PTR_W'(N - 1);

    logic                     len_ok;
    logic                     outlier;
    logic                     candidate;
    logic                     accept;
    logic                     acc_q;
    logic [COUNTER_WIDTH-1:0] sample_q;
    logic [COUNTER_WIDTH-1:0] latest_q;
    logic [PTR_W-1:0]         wr_ptr;
    logic [SUM_W-1:0]         sum;
    logic [SUM_W-1:0]         sum_next;
    logic [COUNTER_WIDTH-1:0] ring_rd;
    logic [COUNTER_WIDTH-1:0] oldest;
    logic                     full;

    always_comb begin
        len_ok    = (last_counter >= min_period) && (last_counter != '0);
        candidate = period_strobe && enable && !freeze && len_ok;
        accept    = candidate && !outlier;
    end

`ifdef COUNTER_OUTLIER_REJECT_EN
    logic [COUNTER_WIDTH-1:0] diff;

    // Compared against the registered reference, so in-flight samples are not yet reflected.
    always_comb begin
        diff    = (last_counter >= reference_counter) ? (last_counter - reference_counter)
                                                      : (reference_counter - last_counter);
        outlier = reference_valid && (tolerance != '0) && (diff > tolerance);
    end

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            rejected_count <= '0;
        end else if (!enable) begin
            rejected_count <= '0;
        end else if (candidate && outlier && (rejected_count != '1)) begin
            rejected_count <= rejected_count + REJECT_COUNT_WIDTH'(1);
        end
    end
`else
    always_comb begin
        outlier = 1'b0;
    end
`endif

    // Stage 0: register the acceptance decision and the sample.
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            acc_q    <= 1'b0;
            sample_q <= '0;
        end else if (!enable) begin
            acc_q    <= 1'b0;
            sample_q <= '0;
        end else begin
            acc_q <= accept;
            if (accept) begin
                sample_q <= last_counter;
            end
        end
    end

    period_ring_buffer #(
        .WIDTH (COUNTER_WIDTH),
        .PTR_W (PTR_W)
    ) u_ring (
        .clk     (clk),
        .wr_en   (acc_q && enable),
        .wr_ptr  (wr_ptr),
        .wr_data (sample_q),
        .rd_data (ring_rd)
    );

    always_comb begin
        full     = (fill_level == FILL_FULL);
        oldest   = full ? ring_rd : '0;
        sum_next = sum + SUM_W'(sample_q) - SUM_W'(oldest);
    end

    // Stage 1: window, running sum and fill level.
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            wr_ptr        <= '0;
            sum           <= '0;
            fill_level    <= '0;
            latest_q      <= '0;
            sample_strobe <= 1'b0;
        end else if (!enable) begin
            wr_ptr        <= '0;
            sum           <= '0;
            fill_level    <= '0;
            latest_q      <= '0;
            sample_strobe <= 1'b0;
        end else begin
            sample_strobe <= acc_q;
            if (acc_q) begin
                wr_ptr   <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + PTR_W'(1);
                sum      <= sum_next;
                latest_q <= sample_q;
                if (!full) begin
                    fill_level <= fill_level + FILL_W'(1);
                end
            end
        end
    end

    // Stage 2: outputs only move when stage 1 moved, so they hold through freeze.
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            reference_counter <= '0;
            reference_valid   <= 1'b0;
        end else if (!enable) begin
            reference_counter <= '0;
            reference_valid   <= 1'b0;
        end else begin
            reference_counter <= full ? COUNTER_WIDTH'(sum >> AVG_LOG2) : latest_q;
            reference_valid   <= full;
        end
    end

endmodule

// File: tb/tb_counter_period_averager.sv
// Self-checking bench for counter_period_averager with N=4; table vectors plus a sample scoreboard.
module tb_counter_period_averager;

    logic        clk = 1'b0;
    logic        aresetn;
    logic        enable;
    logic        freeze;
    logic        period_strobe;
    logic [31:0] last_counter;
    logic [31:0] min_period;
    logic [31:0] reference_counter;
    logic        reference_valid;
    logic [2:0]  fill_level;
    logic        sample_strobe;
`ifdef COUNTER_OUTLIER_REJECT_EN
    logic [31:0] tolerance;
    logic [15:0] rejected_count;
`endif

    always #5 clk = ~clk;

    counter_period_averager #(
        .COUNTER_WIDTH (32),
        .AVG_LOG2      (2)
    ) dut (
        .clk               (clk),
        .aresetn           (aresetn),
        .enable            (enable),
        .freeze            (freeze),
        .period_strobe     (period_strobe),
        .last_counter      (last_counter),
        .min_period        (min_period),
        .reference_counter (reference_counter),
        .reference_valid   (reference_valid),
        .fill_level        (fill_level),
        .sample_strobe     (sample_strobe)
`ifdef COUNTER_OUTLIER_REJECT_EN
       ,.tolerance         (tolerance),
        .rejected_count    (rejected_count)
`endif
    );

    typedef struct {
        logic        en;
        logic        frz;
        logic        stb;
        logic [31:0] val;
        logic [31:0] minp;
        logic        exp_ss;
        logic [2:0]  exp_fill;
        logic [31:0] exp_ref;
        logic        exp_valid;
    } vec_t;

    typedef struct {
        logic [2:0]  fill;
        logic [31:0] refc;
        logic        valid;
    } exp_t;

    vec_t        vecs[12];
    exp_t        sbq[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] b2b_val[5]   = '{32'd20, 32'd30, 32'd40, 32'd50, 32'd51};
    logic [2:0]  b2b_fill[5]  = '{3'd2, 3'd3, 3'd4, 3'd4, 3'd4};
    logic [31:0] b2b_ref[5]   = '{32'd20, 32'd30, 32'd25, 32'd35, 32'd42};
    logic        b2b_valid[5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        enable        = 1'b1;
        freeze        = 1'b0;
        period_strobe = 1'b0;
    endtask

    task automatic push_exp(input logic [2:0] f, input logic [31:0] r, input logic v);
        exp_t e;
        e.fill  = f;
        e.refc  = r;
        e.valid = v;
        sbq.push_back(e);
    endtask

    task automatic strobe(input logic [31:0] val, input logic [31:0] minp);
        enable        = 1'b1;
        freeze        = 1'b0;
        period_strobe = 1'b1;
        last_counter  = val;
        min_period    = minp;
    endtask

    // Scoreboard: each sample_strobe pops one expected entry; reference is checked a cycle later.
    exp_t mon_e;
    exp_t mon_pend_e;
    logic mon_pend = 1'b0;

    initial begin : monitor
        forever begin
            @(posedge clk);
            #1;
            if (mon_pend) begin
                check("sb_reference", reference_counter, mon_pend_e.refc);
                check("sb_reference_valid", 32'(reference_valid), 32'(mon_pend_e.valid));
                mon_pend = 1'b0;
            end
            if (sample_strobe) begin
                if (sbq.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL sb_unexpected_sample: got sample_strobe=1, expected 0");
                end else begin
                    mon_e = sbq.pop_front();
                    check("sb_fill_level", 32'(fill_level), 32'(mon_e.fill));
                    mon_pend_e = mon_e;
                    mon_pend   = 1'b1;
                end
            end
        end
    end

    initial begin : main
        vecs[0]  = '{1'b1, 1'b0, 1'b1, 32'd1000, 32'd10, 1'b1, 3'd1, 32'd1000, 1'b0};
        vecs[1]  = '{1'b1, 1'b0, 1'b1, 32'd1000, 32'd10, 1'b1, 3'd2, 32'd1000, 1'b0};
        vecs[2]  = '{1'b1, 1'b0, 1'b1, 32'd1000, 32'd10, 1'b1, 3'd3, 32'd1000, 1'b0};
        vecs[3]  = '{1'b1, 1'b0, 1'b1, 32'd1000, 32'd10, 1'b1, 3'd4, 32'd1000, 1'b1};
        vecs[4]  = '{1'b1, 1'b0, 1'b1, 32'd1004, 32'd10, 1'b1, 3'd4, 32'd1001, 1'b1};
        vecs[5]  = '{1'b1, 1'b0, 1'b1, 32'd1008, 32'd10, 1'b1, 3'd4, 32'd1003, 1'b1};
        vecs[6]  = '{1'b1, 1'b0, 1'b1, 32'd5,    32'd10, 1'b0, 3'd4, 32'd1003, 1'b1};
        vecs[7]  = '{1'b1, 1'b0, 1'b1, 32'd0,    32'd0,  1'b0, 3'd4, 32'd1003, 1'b1};
        vecs[8]  = '{1'b1, 1'b1, 1'b1, 32'd2000, 32'd10, 1'b0, 3'd4, 32'd1003, 1'b1};
        vecs[9]  = '{1'b0, 1'b0, 1'b1, 32'd2000, 32'd10, 1'b0, 3'd0, 32'd0,    1'b0};
        vecs[10] = '{1'b1, 1'b0, 1'b1, 32'd10,   32'd10, 1'b1, 3'd1, 32'd10,   1'b0};
        vecs[11] = '{1'b1, 1'b0, 1'b1, 32'd9,    32'd10, 1'b0, 3'd1, 32'd10,   1'b0};

        aresetn       = 1'b0;
        enable        = 1'b1;
        freeze        = 1'b0;
        period_strobe = 1'b1;
        last_counter  = 32'd1000;
        min_period    = 32'd10;
`ifdef COUNTER_OUTLIER_REJECT_EN
        tolerance     = 32'd0;
`endif
        repeat (3) step();
        check("reset_reference", reference_counter, 32'd0);
        check("reset_valid", 32'(reference_valid), 32'd0);
        check("reset_fill", 32'(fill_level), 32'd0);
        check("reset_sample_strobe", 32'(sample_strobe), 32'd0);
`ifdef COUNTER_OUTLIER_REJECT_EN
        check("reset_rejected", 32'(rejected_count), 32'd0);
`endif
        period_strobe = 1'b0;
        aresetn       = 1'b1;
        step();

        for (int i = 0; i < 12; i++) begin
            enable        = vecs[i].en;
            freeze        = vecs[i].frz;
            period_strobe = vecs[i].stb;
            last_counter  = vecs[i].val;
            min_period    = vecs[i].minp;
            if (vecs[i].exp_ss) begin
                push_exp(vecs[i].exp_fill, vecs[i].exp_ref, vecs[i].exp_valid);
            end
            step();
            idle();
            step();
            check($sformatf("vec%0d_sample_strobe", i), 32'(sample_strobe), 32'(vecs[i].exp_ss));
            step();
            check($sformatf("vec%0d_fill", i), 32'(fill_level), 32'(vecs[i].exp_fill));
            check($sformatf("vec%0d_reference", i), reference_counter, vecs[i].exp_ref);
            check($sformatf("vec%0d_valid", i), 32'(reference_valid), 32'(vecs[i].exp_valid));
        end

        // Back-to-back strobes; the window wraps and the average truncates (171/4 = 42).
        for (int i = 0; i < 5; i++) begin
            strobe(b2b_val[i], 32'd10);
            push_exp(b2b_fill[i], b2b_ref[i], b2b_valid[i]);
            step();
        end
        idle();
        repeat (4) step();
        check("b2b_final_reference", reference_counter, 32'd42);

        // Strobe in the cycle enable returns high is processed.
        enable = 1'b0;
        step();
        strobe(32'd77, 32'd10);
        push_exp(3'd1, 32'd77, 1'b0);
        step();
        idle();
        repeat (3) step();
        check("release_fill", 32'(fill_level), 32'd1);
        check("release_reference", reference_counter, 32'd77);

`ifdef COUNTER_OUTLIER_REJECT_EN
        enable = 1'b0;
        step();
        for (int i = 0; i < 4; i++) begin
            strobe(32'd1000, 32'd10);
            push_exp(3'(i + 1), 32'd1000, (i == 3));
            step();
        end
        idle();
        repeat (4) step();
        tolerance = 32'd50;
        strobe(32'd1100, 32'd10);
        step();
        idle();
        repeat (3) step();
        check("outlier_rejected_count", 32'(rejected_count), 32'd1);
        check("outlier_reference_hold", reference_counter, 32'd1000);
        check("outlier_fill_hold", 32'(fill_level), 32'd4);
        strobe(32'd1040, 32'd10);
        push_exp(3'd4, 32'd1010, 1'b1);
        step();
        idle();
        repeat (3) step();
        check("inband_reference", reference_counter, 32'd1010);
        check("inband_rejected_count", 32'(rejected_count), 32'd1);
        tolerance = 32'd0;
        enable    = 1'b0;
        step();
        idle();
        step();
        check("clear_rejected_count", 32'(rejected_count), 32'd0);
`endif

        repeat (2) step();
        check("scoreboard_drained", 32'(sbq.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
